// File: rtl/dm_pkg.sv
// Shared types and helpers for the dual-write data memory.
// Byte-lane merge and parity helpers work on a fixed maximum width; callers cast to and from their own width.
package dm_pkg;

  localparam int DM_WORD_ALIGN_BITS = 2;
  localparam int DM_MAX_WIDTH       = 256;
  localparam int DM_MAX_NB          = DM_MAX_WIDTH / 8;

  function automatic logic even_parity8(input logic [7:0] b);
    return ^b;
  endfunction

  // Lanes enabled on port 0 win over port 1; untouched lanes keep the old value.
  function automatic logic [DM_MAX_WIDTH-1:0] lane_merge(
    input logic [DM_MAX_WIDTH-1:0] old_w,
    input logic [DM_MAX_WIDTH-1:0] d0,
    input logic [DM_MAX_NB-1:0]    be0,
    input logic [DM_MAX_WIDTH-1:0] d1,
    input logic [DM_MAX_NB-1:0]    be1
  );
    logic [DM_MAX_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < DM_MAX_NB; i++) begin
      if (be0[i]) begin
        r[i*8 +: 8] = d0[i*8 +: 8];
      end else if (be1[i]) begin
        r[i*8 +: 8] = d1[i*8 +: 8];
      end else begin
        r[i*8 +: 8] = old_w[i*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_addr_chk.sv
// Byte-address decoder: word index plus alignment and range legality.
module dm_addr_chk
  import dm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int AW     = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [AW-1:0]     idx_o,
  output logic              legal_o
);

  assign idx_o   = addr_i[AW+DM_WORD_ALIGN_BITS-1:DM_WORD_ALIGN_BITS];
  assign legal_o = (addr_i[DM_WORD_ALIGN_BITS-1:0] == '0) &&
                   (addr_i[ADDR_W-1:AW+DM_WORD_ALIGN_BITS] == '0);

endmodule

// File: rtl/dm_dualwr_mem.sv
// Data memory with primary and compensation write ports, write-first registered read.
// Optional per-lane even parity storage and checking is enabled with `define DM_PARITY_EN.
module dm_dualwr_mem
  import dm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic              wrc_en,
  input  logic [ADDR_W-1:0] wrc_addr,
  input  logic [WIDTH-1:0]  wrc_data,
  input  logic [WIDTH/8-1:0] wrc_be,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  output logic              wr_conflict,
  output logic              rd_perr
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0] old_w, input logic [WIDTH-1:0] d0, input logic [NB-1:0] be0,
    input logic [WIDTH-1:0] d1, input logic [NB-1:0] be1);
    return WIDTH'(lane_merge(DM_MAX_WIDTH'(old_w), DM_MAX_WIDTH'(d0), DM_MAX_NB'(be0),
                             DM_MAX_WIDTH'(d1), DM_MAX_NB'(be1)));
  endfunction

  function automatic logic [NB-1:0] lane_par(input logic [WIDTH-1:0] w);
    logic [NB-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) begin
      p[i] = even_parity8(w[i*8 +: 8]);
    end
    return p;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_idx_s, wrc_idx_s, rd_idx_s;
  logic          wr_legal_s, wrc_legal_s, rd_legal_s;

  dm_addr_chk #(.ADDR_W(ADDR_W), .AW(AW)) u_wr_chk (
    .addr_i(wr_addr), .idx_o(wr_idx_s), .legal_o(wr_legal_s));
  dm_addr_chk #(.ADDR_W(ADDR_W), .AW(AW)) u_wrc_chk (
    .addr_i(wrc_addr), .idx_o(wrc_idx_s), .legal_o(wrc_legal_s));
  dm_addr_chk #(.ADDR_W(ADDR_W), .AW(AW)) u_rd_chk (
    .addr_i(rd_addr), .idx_o(rd_idx_s), .legal_o(rd_legal_s));

  logic             wr_ok_s, wrc_ok_s, same_word_s;
  logic [NB-1:0]    wr_be_eff_s, wrc_be_eff_s, rd_be0_s, rd_be1_s;
  logic [WIDTH-1:0] wr_word_d, wrc_word_d, rd_word_s;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
  logic             wr_err_q, wr_err_d, wr_conflict_q, wr_conflict_d;

  // Write acceptance, same-word merging and write-first read word selection.
  always_comb begin
    wr_ok_s      = wr_en && wr_legal_s && (wr_be != '0);
    wrc_ok_s     = wrc_en && wrc_legal_s && (wrc_be != '0);
    same_word_s  = wr_ok_s && wrc_ok_s && (wr_idx_s == wrc_idx_s);
    wr_be_eff_s  = wr_ok_s ? wr_be : '0;
    wrc_be_eff_s = wrc_ok_s ? wrc_be : '0;
    wr_word_d  = merge_w(mem_q[wr_idx_s], wr_data, wr_be_eff_s,
                         wrc_data, same_word_s ? wrc_be_eff_s : '0);
    wrc_word_d = merge_w(mem_q[wrc_idx_s], wr_data, same_word_s ? wr_be_eff_s : '0,
                         wrc_data, wrc_be_eff_s);
    rd_be0_s  = (wr_ok_s && (wr_idx_s == rd_idx_s)) ? wr_be : '0;
    rd_be1_s  = (wrc_ok_s && (wrc_idx_s == rd_idx_s)) ? wrc_be : '0;
    rd_word_s = merge_w(mem_q[rd_idx_s], wr_data, rd_be0_s, wrc_data, rd_be1_s);

    wr_err_d      = (wr_en && (wr_be != '0) && !wr_legal_s) ||
                    (wrc_en && (wrc_be != '0) && !wrc_legal_s);
    wr_conflict_d = same_word_s && ((wr_be & wrc_be) != '0);
    rd_valid_d    = rd_req;
    rd_err_d      = rd_req && !rd_legal_s;
    if (rd_req) begin
      rd_data_d = rd_legal_s ? rd_word_s : '0;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Word storage and registered status/read outputs.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_err_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      if (wrc_ok_s) begin
        mem_q[wrc_idx_s] <= wrc_word_d;
      end
      if (wr_ok_s) begin
        mem_q[wr_idx_s] <= wr_word_d;
      end
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_err_q      <= rd_err_d;
      wr_err_q      <= wr_err_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

`ifdef DM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_lanes_s, wrc_lanes_s, rd_lanes_s, wr_par_d, wrc_par_d;
  logic          rd_perr_q, rd_perr_d;

  // Lane parity follows written lanes; bypassed lanes carry fresh parity so they never flag.
  always_comb begin
    wr_lanes_s  = wr_be_eff_s | (same_word_s ? wrc_be_eff_s : '0);
    wrc_lanes_s = wrc_be_eff_s | (same_word_s ? wr_be_eff_s : '0);
    wr_par_d    = (par_q[wr_idx_s] & ~wr_lanes_s) | (lane_par(wr_word_d) & wr_lanes_s);
    wrc_par_d   = (par_q[wrc_idx_s] & ~wrc_lanes_s) | (lane_par(wrc_word_d) & wrc_lanes_s);
    rd_lanes_s  = rd_be0_s | rd_be1_s;
    rd_perr_d   = rd_req && rd_legal_s &&
                  (((par_q[rd_idx_s] ^ lane_par(mem_q[rd_idx_s])) & ~rd_lanes_s) != '0);
  end

  // Parity storage and registered parity error flag.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= '0;
      end
      rd_perr_q <= 1'b0;
    end else begin
      if (wrc_ok_s) begin
        par_q[wrc_idx_s] <= wrc_par_d;
      end
      if (wr_ok_s) begin
        par_q[wr_idx_s] <= wr_par_d;
      end
      rd_perr_q <= rd_perr_d;
    end
  end

  assign rd_perr = rd_perr_q;
`else
  assign rd_perr = 1'b0;
`endif

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign wr_err      = wr_err_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_dm_dualwr_mem.sv
// Directed scoreboard bench for dm_dualwr_mem; parity steps run when DM_PARITY_EN is defined.
module tb_dm_dualwr_mem;

  logic        clk, reset;
  logic        wr_en, wrc_en, rd_req;
  logic [31:0] wr_addr, wrc_addr, rd_addr, wr_data, wrc_data;
  logic [3:0]  wr_be, wrc_be;
  logic [31:0] rd_data;
  logic        rd_valid, rd_err, wr_err, wr_conflict, rd_perr;

  dm_dualwr_mem #(.WIDTH(32), .DEPTH(16), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wrc_en(wrc_en), .wrc_addr(wrc_addr), .wrc_data(wrc_data), .wrc_be(wrc_be),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .wr_err(wr_err), .wr_conflict(wr_conflict), .rd_perr(rd_perr));

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        p;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_d = 32'h0;
  logic        exp_wr_err = 1'b0;
  logic        exp_conf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_be = 4'h0;
    wrc_en = 1'b0; wrc_addr = 32'h0; wrc_data = 32'h0; wrc_be = 4'h0;
    rd_req = 1'b0; rd_addr = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic wrc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wrc_en = 1'b1; wrc_addr = a; wrc_data = d; wrc_be = be;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e, input logic p);
    rd_exp_t x;
    rd_req = 1'b1; rd_addr = a;
    x.d = d; x.e = e; x.p = p;
    rd_q.push_back(x);
  endtask

  // One cycle: let the negedge sample, then compare all outputs against expectations.
  task automatic tick();
    rd_exp_t x;
    @(negedge clk);
    #1;
    if (rd_q.size() > 0) begin
      x = rd_q.pop_front();
      chk("rd_valid", {31'h0, rd_valid}, 32'h1);
      chk("rd_data", rd_data, x.d);
      chk("rd_err", {31'h0, rd_err}, {31'h0, x.e});
      chk("rd_perr", {31'h0, rd_perr}, {31'h0, x.p});
      last_d = x.d;
    end else begin
      chk("rd_valid_idle", {31'h0, rd_valid}, 32'h0);
      chk("rd_data_hold", rd_data, last_d);
      chk("rd_err_idle", {31'h0, rd_err}, 32'h0);
    end
    chk("wr_err", {31'h0, wr_err}, {31'h0, exp_wr_err});
    chk("wr_conflict", {31'h0, wr_conflict}, {31'h0, exp_conf});
    exp_wr_err = 1'b0;
    exp_conf   = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_wr_err", {31'h0, wr_err}, 32'h0);
    @(posedge clk);
    reset = 1'b1;

    for (int a = 0; a < 16; a++) begin
      rd(32'(a * 4), 32'h0, 1'b0, 1'b0);
      tick();
    end
    tick();

    wr(32'h8, 32'hDEADBEEF, 4'hF); tick();
    rd(32'h8, 32'hDEADBEEF, 1'b0, 1'b0); tick();
    tick();

    wr(32'h10, 32'h11111111, 4'h3); wrc(32'h10, 32'h22222222, 4'h6);
    exp_conf = 1'b1; tick();
    rd(32'h10, 32'h00221111, 1'b0, 1'b0); tick();

    wr(32'h14, 32'hCAFEF00D, 4'hF); rd(32'h14, 32'hCAFEF00D, 1'b0, 1'b0); tick();
    rd(32'h14, 32'hCAFEF00D, 1'b0, 1'b0); tick();

    wr(32'h18, 32'hAAAAAAAA, 4'h1); wrc(32'h18, 32'hBBBBBBBB, 4'h3);
    rd(32'h18, 32'h0000BBAA, 1'b0, 1'b0); exp_conf = 1'b1; tick();

    wr(32'h1C, 32'h12345678, 4'hF); wrc(32'h20, 32'h9ABCDEF0, 4'hF); tick();
    rd(32'h1C, 32'h12345678, 1'b0, 1'b0); tick();
    rd(32'h20, 32'h9ABCDEF0, 1'b0, 1'b0); tick();

    wr(32'h41, 32'h55555555, 4'hF); exp_wr_err = 1'b1; tick();
    wr(32'h40, 32'h66666666, 4'hF); exp_wr_err = 1'b1; tick();
    wrc(32'h0A, 32'h77777777, 4'hF); exp_wr_err = 1'b1; tick();
    rd(32'h40, 32'h0, 1'b1, 1'b0); tick();
    rd(32'h0, 32'h0, 1'b0, 1'b0); tick();
    rd(32'h9, 32'h0, 1'b1, 1'b0); tick();
    rd(32'h8, 32'hDEADBEEF, 1'b0, 1'b0); tick();

    wr(32'h8, 32'hFFFFFFFF, 4'h0); tick();
    rd(32'h8, 32'hDEADBEEF, 1'b0, 1'b0); tick();
    tick();

`ifdef DM_PARITY_EN
    wr(32'h24, 32'h00000055, 4'hF); tick();
    rd(32'h24, 32'h00000055, 1'b0, 1'b0); tick();
    dut.par_q[9][0] = ~dut.par_q[9][0];
    rd(32'h24, 32'h00000055, 1'b0, 1'b1); tick();
    wr(32'h24, 32'h00000056, 4'h1); rd(32'h24, 32'h00000056, 1'b0, 1'b0); tick();
`endif

    rd(32'h8, 32'hDEADBEEF, 1'b0, 1'b0); tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_mid_rd_data", rd_data, 32'h0);
    rd_q.delete();
    last_d = 32'h0;
    @(posedge clk);
    reset = 1'b1;
    rd(32'h8, 32'h0, 1'b0, 1'b0); tick();
    rd(32'h10, 32'h0, 1'b0, 1'b0); tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
